sobel_pipe_accelerator: RTL and testbench

Next-generation Sobel convolution core: a parametrised lane count and pixel width, with a 3-stage valid/ready pipeline replacing the purely combinational core. It sits between the Sobel image row registers and the output write path. It takes three stacked image-row windows and produces NUM_LANES filtered pixels per accepted word. It adds selectable gradient-combine modes, binary thresholding, stall handling and a processed-word counter.

---
 rtl/sobel_pipe_accelerator.sv | 156 +++++++++++++++
 tb/tb_sobel_pipe_accelerator.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pipe_accelerator.sv
// Multi-lane Sobel edge filter behind a three-stage valid/ready pipeline.
// The stages are gradients, then clamped magnitudes, then the mode combine that feeds the output register.
module sobel_pipe_accelerator #(
  parameter int NUM_LANES = 8,
  parameter int PIX_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              srow2sacc_valid,
  output logic                              sacc2srow_ready,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] srow2sacc_row1_data,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] srow2sacc_row2_data,
  input  logic [(NUM_LANES+2)*PIX_WIDTH-1:0] srow2sacc_row3_data,
  input  logic [1:0]                        srow2sacc_mode,
  input  logic [PIX_WIDTH-1:0]              srow2sacc_threshold,
  output logic                              sacc2swt_valid,
  input  logic                              swt2sacc_ready,
  output logic [NUM_LANES*PIX_WIDTH-1:0]    sacc2swt_write_data,
  output logic [CNT_WIDTH-1:0]              sacc_word_count
);

  localparam int IW = (NUM_LANES + 2) * PIX_WIDTH;
  localparam int OW = NUM_LANES * PIX_WIDTH;
  localparam int GW = PIX_WIDTH + 4;
  localparam logic [PIX_WIDTH-1:0] PIX_MAX = {PIX_WIDTH{1'b1}};

  typedef logic signed [GW-1:0] grad_t;
  typedef logic [PIX_WIDTH-1:0] pix_t;

  function automatic grad_t px(input logic [IW-1:0] row, input int k);
    return grad_t'({4'b0000, row[k*PIX_WIDTH +: PIX_WIDTH]});
  endfunction

  function automatic pix_t abs_clamp(input grad_t g);
    grad_t mag;
    mag = g[GW-1] ? -g : g;
    return (mag > grad_t'({4'b0000, PIX_MAX})) ? PIX_MAX : mag[PIX_WIDTH-1:0];
  endfunction

  function automatic pix_t combine(input pix_t ax, input pix_t ay, input pix_t ctr,
                                   input logic [1:0] mode, input pix_t thr);
    logic [PIX_WIDTH:0] sum;
    pix_t sat;
    pix_t res;
    sum = {1'b0, ax} + {1'b0, ay};
    sat = sum[PIX_WIDTH] ? PIX_MAX : sum[PIX_WIDTH-1:0];
    case (mode)
      2'b00:   res = sat;
      2'b01:   res = (ax > ay) ? ax : ay;
      2'b10:   res = (sat >= thr) ? PIX_MAX : '0;
      default: res = ctr;
    endcase
    return res;
  endfunction

  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic in_fire, out_fire;

  grad_t      gx_d [NUM_LANES];
  grad_t      gy_d [NUM_LANES];
  pix_t       ctr_d [NUM_LANES];
  grad_t      s1_gx [NUM_LANES];
  grad_t      s1_gy [NUM_LANES];
  pix_t       s1_ctr [NUM_LANES];
  logic [1:0] s1_mode;
  pix_t       s1_thr;
  pix_t       s2_ax [NUM_LANES];
  pix_t       s2_ay [NUM_LANES];
  pix_t       s2_ctr [NUM_LANES];
  logic [1:0] s2_mode;
  pix_t       s2_thr;
  logic [OW-1:0] out_d;
  logic [OW-1:0] out_data;

  // Lane c sees pixels k = c (right), c+1 (middle), c+2 (left).
  always_comb begin
    for (int c = 0; c < NUM_LANES; c++) begin
      gx_d[c] = (px(srow2sacc_row1_data, c+2) + (px(srow2sacc_row1_data, c+1) <<< 1)
                 + px(srow2sacc_row1_data, c))
              - (px(srow2sacc_row3_data, c+2) + (px(srow2sacc_row3_data, c+1) <<< 1)
                 + px(srow2sacc_row3_data, c));
      gy_d[c] = (px(srow2sacc_row1_data, c+2) + (px(srow2sacc_row2_data, c+2) <<< 1)
                 + px(srow2sacc_row3_data, c+2))
              - (px(srow2sacc_row1_data, c) + (px(srow2sacc_row2_data, c) <<< 1)
                 + px(srow2sacc_row3_data, c));
      ctr_d[c] = srow2sacc_row2_data[(c+1)*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  always_comb begin
    out_d = '0;
    for (int c = 0; c < NUM_LANES; c++) begin
      out_d[c*PIX_WIDTH +: PIX_WIDTH] = combine(s2_ax[c], s2_ay[c], s2_ctr[c], s2_mode, s2_thr);
    end
  end

  // Ready ripples back from the output; a stage may load whenever it is empty or draining.
  assign s3_ready        = !s3_valid || swt2sacc_ready;
  assign s2_ready        = !s2_valid || s3_ready;
  assign s1_ready        = !s1_valid || s2_ready;
  assign sacc2srow_ready = s1_ready && !flush;
  assign in_fire         = srow2sacc_valid && sacc2srow_ready;
  assign out_fire        = s3_valid && swt2sacc_ready;

  assign sacc2swt_valid      = s3_valid;
  assign sacc2swt_write_data = out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      s3_valid        <= 1'b0;
      out_data        <= '0;
      sacc_word_count <= '0;
    end else if (flush) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      s3_valid        <= 1'b0;
      sacc_word_count <= '0;
    end else begin
      if (s1_ready) s1_valid <= in_fire;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) begin
        s3_valid <= s2_valid;
        if (s2_valid) out_data <= out_d;
      end
      if (out_fire) sacc_word_count <= sacc_word_count + CNT_WIDTH'(1);
    end
  end

  // Intermediate data needs no reset; its validity is tracked by the stage valid bits.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_mode <= srow2sacc_mode;
      s1_thr  <= srow2sacc_threshold;
      for (int c = 0; c < NUM_LANES; c++) begin
        s1_gx[c]  <= gx_d[c];
        s1_gy[c]  <= gy_d[c];
        s1_ctr[c] <= ctr_d[c];
      end
    end
    if (s2_ready && s1_valid) begin
      s2_mode <= s1_mode;
      s2_thr  <= s1_thr;
      for (int c = 0; c < NUM_LANES; c++) begin
        s2_ax[c]  <= abs_clamp(s1_gx[c]);
        s2_ay[c]  <= abs_clamp(s1_gy[c]);
        s2_ctr[c] <= s1_ctr[c];
      end
    end
  end

endmodule

// File: tb/tb_sobel_pipe_accelerator.sv
// Bench for sobel_pipe_accelerator: a scoreboard fed from an integer Sobel model, plus a
// second narrow build that exercises counter wrap and the 10-bit pixel scaling.
module tb_sobel_pipe_accelerator;

  localparam int NL = 8, PW = 8, CW = 16;
  localparam int IW = (NL + 2) * PW, OW = NL * PW;
  localparam int MAXV = (1 << PW) - 1;
  localparam int NL2 = 4, PW2 = 10, CW2 = 4;
  localparam int IW2 = (NL2 + 2) * PW2, OW2 = NL2 * PW2;

  logic clk, reset, flush;
  logic srow2sacc_valid, sacc2srow_ready, sacc2swt_valid, swt2sacc_ready;
  logic [IW-1:0] row1, row2, row3;
  logic [1:0] mode;
  logic [PW-1:0] thr;
  logic [OW-1:0] sacc2swt_write_data;
  logic [CW-1:0] sacc_word_count;

  logic valid_b, ready_in_b, out_valid_b, flush_b, out_ready_b;
  logic [IW2-1:0] row1_b, row2_b, row3_b;
  logic [OW2-1:0] data_b;
  logic [CW2-1:0] count_b;

  int checks = 0, errors = 0, exp_count = 0;
  int n_out_b = 0;
  logic [OW-1:0] sb[$];

  sobel_pipe_accelerator #(.NUM_LANES(NL), .PIX_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .srow2sacc_valid(srow2sacc_valid), .sacc2srow_ready(sacc2srow_ready),
    .srow2sacc_row1_data(row1), .srow2sacc_row2_data(row2), .srow2sacc_row3_data(row3),
    .srow2sacc_mode(mode), .srow2sacc_threshold(thr),
    .sacc2swt_valid(sacc2swt_valid), .swt2sacc_ready(swt2sacc_ready),
    .sacc2swt_write_data(sacc2swt_write_data), .sacc_word_count(sacc_word_count)
  );

  sobel_pipe_accelerator #(.NUM_LANES(NL2), .PIX_WIDTH(PW2), .CNT_WIDTH(CW2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b),
    .srow2sacc_valid(valid_b), .sacc2srow_ready(ready_in_b),
    .srow2sacc_row1_data(row1_b), .srow2sacc_row2_data(row2_b), .srow2sacc_row3_data(row3_b),
    .srow2sacc_mode(2'b00), .srow2sacc_threshold(10'h000),
    .sacc2swt_valid(out_valid_b), .swt2sacc_ready(out_ready_b),
    .sacc2swt_write_data(data_b), .sacc_word_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] fill(input logic [PW-1:0] v);
    return {(NL+2){v}};
  endfunction

  // Reference filter in plain integers, straight from the 3x3 kernel definitions.
  function automatic logic [OW-1:0] model(input logic [IW-1:0] r1, input logic [IW-1:0] r2,
                                          input logic [IW-1:0] r3, input logic [1:0] m,
                                          input logic [PW-1:0] t);
    logic [IW-1:0] rw [3];
    logic [OW-1:0] w;
    int p [3][3];
    int gx, gy, ax, ay, s, res;
    rw[0] = r1; rw[1] = r2; rw[2] = r3;
    w = '0;
    for (int c = 0; c < NL; c++) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          p[r][k] = int'(rw[r][(c+k)*PW +: PW]);
      gx = (p[0][2] + 2*p[0][1] + p[0][0]) - (p[2][2] + 2*p[2][1] + p[2][0]);
      gy = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      if (ax > MAXV) ax = MAXV;
      if (ay > MAXV) ay = MAXV;
      s = (ax + ay > MAXV) ? MAXV : ax + ay;
      case (m)
        2'b00:   res = s;
        2'b01:   res = (ax > ay) ? ax : ay;
        2'b10:   res = (s >= int'(t)) ? MAXV : 0;
        default: res = p[1][1];
      endcase
      w[c*PW +: PW] = PW'(res);
    end
    return w;
  endfunction

  // Push on every input handshake, pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (srow2sacc_valid && sacc2srow_ready)
        sb.push_back(model(row1, row2, row3, mode, thr));
      if (sacc2swt_valid && swt2sacc_ready) begin
        checkOutput("output_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          checkOutput("lane_data", sacc2swt_write_data, sb.pop_front());
          exp_count++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b) begin
      checkOutput("scaled_lane", 64'(data_b), 64'({NL2{10'h100}}));
      n_out_b++;
    end
  end

  task automatic applyStimulus(input logic [IW-1:0] a, input logic [IW-1:0] b,
                               input logic [IW-1:0] c, input logic [1:0] m,
                               input logic [PW-1:0] t);
    logic acc;
    int n;
    row1 = a; row2 = b; row3 = c; mode = m; thr = t;
    srow2sacc_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = sacc2srow_ready;
      @(posedge clk);
      #1;
      n++;
    end
    srow2sacc_valid = 1'b0;
    checkOutput("accepted", 64'(acc), 64'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    swt2sacc_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    checkOutput("word_count", 64'(sacc_word_count), 64'(CW'(exp_count)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [IW-1:0] col, zero;
    logic [95:0] rnd1, rnd2, rnd3;
    logic [IW-1:0] bp1 [5];
    logic [IW-1:0] bp2 [5];
    logic [IW-1:0] bp3 [5];
    logic [OW-1:0] held;
    int lat, idx, changes, seen, acc_b;
    logic a;

    reset = 1'b1; flush = 1'b0; srow2sacc_valid = 1'b0; swt2sacc_ready = 1'b1;
    row1 = '0; row2 = '0; row3 = '0; mode = 2'b00; thr = '0;
    valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
    row1_b = '0; row2_b = '0; row3_b = '0;
    zero = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(sacc2swt_valid), 64'd0);
    checkOutput("reset_data", sacc2swt_write_data, 64'd0);
    checkOutput("reset_count", 64'(sacc_word_count), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_ready", 64'(sacc2srow_ready), 64'd1);
    @(posedge clk);
    #1;

    // Uniform field: no gradient; output register loads on the third edge counting the accept edge.
    applyStimulus(fill(8'h80), fill(8'h80), fill(8'h80), 2'b00, 8'h00);
    lat = 1;
    while (!sacc2swt_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency_edges", 64'(lat), 64'd3);
    waitDrain();

    // Horizontal edge of height 0x10, both polarities, every mode.
    applyStimulus(fill(8'h10), zero, zero, 2'b00, 8'h00);
    applyStimulus(fill(8'h10), zero, zero, 2'b01, 8'h00);
    applyStimulus(fill(8'h10), zero, zero, 2'b10, 8'h32);
    applyStimulus(fill(8'h10), zero, zero, 2'b10, 8'h64);
    applyStimulus(zero, zero, fill(8'h10), 2'b00, 8'h00);
    applyStimulus(zero, zero, fill(8'h10), 2'b01, 8'h00);
    applyStimulus(zero, zero, fill(8'h10), 2'b10, 8'h32);
    applyStimulus(zero, zero, fill(8'h10), 2'b10, 8'h64);
    waitDrain();

    // Saturation: bright top row plus a bright left column for lane 0.
    col = '0;
    col[2*PW +: PW] = 8'hFF;
    applyStimulus(fill(8'hFF), col, col, 2'b00, 8'h00);
    applyStimulus(fill(8'hFF), col, col, 2'b01, 8'h00);
    applyStimulus(fill(8'hFF), col, col, 2'b10, 8'hFF);
    applyStimulus(fill(8'hFF), col, col, 2'b11, 8'h00);
    waitDrain();

    // Random words with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rnd1 = {$urandom(), $urandom(), $urandom()};
          rnd2 = {$urandom(), $urandom(), $urandom()};
          rnd3 = {$urandom(), $urandom(), $urandom()};
          applyStimulus(rnd1[IW-1:0], rnd2[IW-1:0], rnd3[IW-1:0],
                        2'($urandom_range(0, 3)), PW'($urandom_range(0, MAXV)));
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          swt2sacc_ready = 1'($urandom_range(0, 1));
        end
        swt2sacc_ready = 1'b1;
      end
    join
    waitDrain();

    // Flush with a word on the input: refused, pipeline and counter cleared.
    applyStimulus(fill(8'h33), zero, fill(8'h05), 2'b00, 8'h00);
    flush = 1'b1;
    srow2sacc_valid = 1'b1;
    #2;
    checkOutput("flush_ready", 64'(sacc2srow_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    srow2sacc_valid = 1'b0;
    sb.delete();
    exp_count = 0;
    checkOutput("flush_count", 64'(sacc_word_count), 64'd0);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (sacc2swt_valid) seen++;
    end
    checkOutput("flush_no_output", 64'(seen), 64'd0);

    // Back-pressure: five words offered, three held, output frozen, then released in order.
    for (int i = 0; i < 5; i++) begin
      rnd1 = {$urandom(), $urandom(), $urandom()};
      rnd2 = {$urandom(), $urandom(), $urandom()};
      rnd3 = {$urandom(), $urandom(), $urandom()};
      bp1[i] = rnd1[IW-1:0]; bp2[i] = rnd2[IW-1:0]; bp3[i] = rnd3[IW-1:0];
    end
    swt2sacc_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (idx < 5) begin
        row1 = bp1[idx]; row2 = bp2[idx]; row3 = bp3[idx]; mode = 2'b00; thr = '0;
        srow2sacc_valid = 1'b1;
      end
      @(negedge clk);
      a = sacc2srow_ready && srow2sacc_valid;
      @(posedge clk);
      #1;
      if (a) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd3);
    checkOutput("bp_ready", 64'(sacc2srow_ready), 64'd0);
    checkOutput("bp_valid", 64'(sacc2swt_valid), 64'd1);
    held = sacc2swt_write_data;
    changes = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (sacc2swt_write_data !== held || !sacc2swt_valid) changes++;
    end
    checkOutput("bp_stable", 64'(changes), 64'd0);
    swt2sacc_ready = 1'b1;
    while (idx < 5) begin
      applyStimulus(bp1[idx], bp2[idx], bp3[idx], 2'b00, 8'h00);
      idx++;
    end
    waitDrain();
    checkOutput("bp_count", 64'(sacc_word_count), 64'd5);

    // Asynchronous reset between edges with two words in flight.
    applyStimulus(fill(8'h20), zero, zero, 2'b00, 8'h00);
    applyStimulus(fill(8'h40), zero, zero, 2'b01, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("inflight_valid", 64'(sacc2swt_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", 64'(sacc2swt_valid), 64'd0);
    checkOutput("async_data", sacc2swt_write_data, 64'd0);
    checkOutput("async_count", 64'(sacc_word_count), 64'd0);
    sb.delete();
    exp_count = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (sacc2swt_valid) seen++;
    end
    checkOutput("no_stale_output", 64'(seen), 64'd0);
    checkOutput("post_reset_count", 64'(sacc_word_count), 64'd0);

    // Narrow build: 10-bit edge of 0x040 gives 0x100 per lane; 17 words wrap a 4-bit counter to 1.
    row1_b = {(NL2+2){10'h040}};
    valid_b = 1'b1;
    acc_b = 0;
    for (int cyc = 0; cyc < 40 && acc_b < 17; cyc++) begin
      @(negedge clk);
      if (ready_in_b) acc_b++;
      @(posedge clk);
      #1;
    end
    valid_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("scaled_accepted", 64'(acc_b), 64'd17);
    checkOutput("scaled_outputs", 64'(n_out_b), 64'd17);
    checkOutput("count_wrap", 64'(count_b), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
